mem_burst_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_rr2.sv | 27 ++
 rtl/mem_burst_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory burst arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RDATA,
    WDATA,
    DONE
  } mem_arb_state_e;

  typedef enum logic {
    ICACHE,
    DCACHE
  } mem_master_e;

  localparam int DEF_READ_BURST_LEN  = 8;
  localparam int DEF_WRITE_BURST_LEN = 8;

  // Counter must hold indices up to the longer burst; never narrower than 1 bit.
  function automatic int beat_cnt_w(input int rd_len, input int wr_len);
    int m;
    m = (rd_len > wr_len) ? rd_len : wr_len;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker; last_grant advances only when update is enabled.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic upd_en_i,
  input  logic upd_dcache_i,
  output logic pick_dcache_o
);

  mem_master_e last_grant_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_grant_q <= ICACHE;
    end else if (upd_en_i) begin
      last_grant_q <= upd_dcache_i ? DCACHE : ICACHE;
    end
  end

  // On a tie the master that was not served last wins.
  assign pick_dcache_o = d_req_i & (~i_req_i | (last_grant_q == ICACHE));

endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one memory burst port between icache refill and dcache refill/writeback,
// holding the grant for a full fixed-length burst.
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int READ_BURST_LEN  = DEF_READ_BURST_LEN,
  parameter int WRITE_BURST_LEN = DEF_WRITE_BURST_LEN
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       i_req,
  input  logic [DATA_ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0]      i_rdata,
  output logic                       i_rvalid,
  output logic                       i_done,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [DATA_ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]      d_wdata,
  input  logic                       d_wvalid,
  output logic                       d_wready,
  output logic [DATA_WIDTH-1:0]      d_rdata,
  output logic                       d_rvalid,
  output logic                       d_done,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  input  logic                       mem_ack,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic                       mem_wvalid,
  input  logic                       mem_wready,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_rvalid
);

  localparam int CNT_W = beat_cnt_w(READ_BURST_LEN, WRITE_BURST_LEN);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_BURST_LEN - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BURST_LEN - 1);

  mem_arb_state_e             state_q;
  mem_master_e                gnt_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic                       mem_req_q;
  logic                       mem_we_q;
  logic [DATA_ADDR_WIDTH-1:0] mem_addr_q;
  logic                       i_done_q;
  logic                       d_done_q;
  logic                       pick_dcache;
  logic                       rd_act;
  logic                       wr_act;
  logic                       gnt_d;

  mem_arb_rr2 u_rr2 (
    .clk_i        (sys_clk),
    .rst_n_i      (sys_rst_n),
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .upd_en_i     ((state_q == CMD) & mem_ack),
    .upd_dcache_i (gnt_d),
    .pick_dcache_o(pick_dcache)
  );

  assign gnt_d = (gnt_q == DCACHE);
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= ICACHE;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            gnt_q      <= pick_dcache ? DCACHE : ICACHE;
            mem_req_q  <= 1'b1;
            mem_we_q   <= pick_dcache & d_we;
            mem_addr_q <= pick_dcache ? d_addr : i_addr;
            state_q    <= CMD;
          end
        end
        CMD: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= mem_we_q ? WDATA : RDATA;
          end
        end
        RDATA: begin
          if (mem_rvalid) begin
            cnt_q <= cnt_d;
            if (cnt_q == RD_LAST) begin
              state_q  <= DONE;
              i_done_q <= ~gnt_d;
              d_done_q <= gnt_d;
            end
          end
        end
        WDATA: begin
          if (d_wvalid & mem_wready) begin
            cnt_q <= cnt_d;
            if (cnt_q == WR_LAST) begin
              state_q  <= DONE;
              d_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data steering is gated by state so stray beats outside a burst never leak through.
  assign rd_act     = (state_q == RDATA);
  assign wr_act     = (state_q == WDATA);

  assign i_rdata    = rd_act ? mem_rdata : '0;
  assign d_rdata    = rd_act ? mem_rdata : '0;
  assign i_rvalid   = rd_act & mem_rvalid & ~gnt_d;
  assign d_rvalid   = rd_act & mem_rvalid & gnt_d;

  assign mem_wdata  = wr_act ? d_wdata : '0;
  assign mem_wvalid = wr_act & d_wvalid;
  assign d_wready   = wr_act & mem_wready;

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign i_done     = i_done_q;
  assign d_done     = d_done_q;

endmodule
